// File: rtl/load_unit_ctrl_if.sv
// Pipeline load request, write-back and data-memory handshake signals for the
// load unit. slave is the controller's view; master is the surrounding system.
interface load_unit_ctrl_if #(
  parameter int XLEN = 32
);
  logic            ld_valid;
  logic            ld_ready;
  logic [2:0]      ld_funct3;
  logic [XLEN-1:0] ld_addr;
  logic            dmem_req;
  logic [XLEN-1:0] dmem_addr;
  logic            dmem_gnt;
  logic            dmem_rvalid;
  logic [XLEN-1:0] dmem_rdata;
  logic            wb_valid;
  logic [XLEN-1:0] wb_data;
  logic            stall;
  logic            misalign_err;
  logic            timeout_err;

  modport slave (
    input  ld_valid, ld_funct3, ld_addr, dmem_gnt, dmem_rvalid, dmem_rdata,
    output ld_ready, dmem_req, dmem_addr, wb_valid, wb_data, stall,
           misalign_err, timeout_err
  );

  modport master (
    output ld_valid, ld_funct3, ld_addr, dmem_gnt, dmem_rvalid, dmem_rdata,
    input  ld_ready, dmem_req, dmem_addr, wb_valid, wb_data, stall,
           misalign_err, timeout_err
  );
endinterface

// File: rtl/load_unit_ctrl.sv
// MEM-stage load sequencer: one outstanding load, word-aligned dmem request,
// byte/halfword extraction with sign/zero extension and a response timeout.
//
// state | meaning
// IDLE  | ready for a load; legality checked on ld_valid
// REQ   | dmem_req held until dmem_gnt (gnt+rvalid together completes)
// WAIT  | granted, waiting for dmem_rvalid
module load_unit_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input logic             clk,
  input logic             rst,
  load_unit_ctrl_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] F_LB  = 3'b000;
  localparam logic [2:0] F_LH  = 3'b001;
  localparam logic [2:0] F_LW  = 3'b010;
  localparam logic [2:0] F_LBU = 3'b100;
  localparam logic [2:0] F_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [CW-1:0]   cnt_q;
  logic            req_q;
  logic [XLEN-1:0] addr_q;
  logic            wb_valid_q;
  logic [XLEN-1:0] wb_data_q;
  logic            mis_q;
  logic            to_q;
  logic [XLEN-1:0] wb_word;
  logic            expired;

  function automatic logic is_legal(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F_LB, F_LBU: return 1'b1;
      F_LH, F_LHU: return ~a[0];
      F_LW:        return (a == 2'b00);
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extract(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [XLEN-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F_LB:    return {{(XLEN-8){b[7]}}, b};
      F_LBU:   return {{(XLEN-8){1'b0}}, b};
      F_LH:    return {{(XLEN-16){h[15]}}, h};
      F_LHU:   return {{(XLEN-16){1'b0}}, h};
      default: return w;
    endcase
  endfunction

  assign wb_word = extract(f3_q, off_q, bus.dmem_rdata);
  // Counter holds (cycles in REQ/WAIT - 1); this edge is the last one allowed.
  assign expired = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      mis_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      to_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.ld_valid) begin
            if (!is_legal(bus.ld_funct3, bus.ld_addr[1:0])) begin
              mis_q <= 1'b1;
            end else begin
              f3_q    <= bus.ld_funct3;
              off_q   <= bus.ld_addr[1:0];
              addr_q  <= {bus.ld_addr[XLEN-1:2], 2'b00};
              cnt_q   <= '0;
              req_q   <= 1'b1;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.dmem_gnt && bus.dmem_rvalid) begin
            req_q      <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_data_q  <= wb_word;
            state_q    <= IDLE;
          end else if (expired) begin
            req_q   <= 1'b0;
            to_q    <= 1'b1;
            state_q <= IDLE;
          end else if (bus.dmem_gnt) begin
            req_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.dmem_rvalid) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= wb_word;
            state_q    <= IDLE;
          end else if (expired) begin
            to_q    <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ld_ready     = (state_q == IDLE);
  assign bus.stall        = (state_q != IDLE);
  assign bus.dmem_req     = req_q;
  assign bus.dmem_addr    = addr_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.misalign_err = mis_q;
  assign bus.timeout_err  = to_q;

endmodule
